// File: rtl/team_08_cactus_scroller.sv
`timescale 1ns/1ps
// Cactus obstacle scroller: moves up to NUM_SLOTS obstacles left once per frame,
// spawns new ones at the right edge after an LFSR-derived gap, flags covered pixels.
module team_08_cactus_scroller #(
    parameter int         NUM_SLOTS = 3,
    parameter int         SPEED     = 4,
    parameter int         CACTUS_W  = 12,
    parameter int         SHORT_H   = 20,
    parameter int         TALL_H    = 32,
    parameter int         FLOOR_Y   = 200,
    parameter int         MIN_GAP   = 40,
    parameter logic [4:0] GAP_MASK  = 5'h1F
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic       clear,
    input  logic       frame_tick,
    input  logic [8:0] x,
    input  logic [7:0] y,
    output logic       r_cactus,
    output logic       passed,
    output logic [1:0] active_cnt
);

    localparam int                 GAP_W     = $clog2(MIN_GAP + 32);
    localparam logic signed [9:0]  SPAWN_X   = 10'sd320;
    localparam logic signed [10:0] CW_S      = 11'(CACTUS_W);
    localparam logic signed [10:0] SPEED_S   = 11'(SPEED);
    localparam logic signed [10:0] FLOOR_S   = 11'(FLOOR_Y);
    localparam logic signed [10:0] SHORT_TOP = 11'(FLOOR_Y - SHORT_H);
    localparam logic signed [10:0] TALL_TOP  = 11'(FLOOR_Y - TALL_H);
    localparam logic [GAP_W-1:0]   GAP_RST   = GAP_W'(MIN_GAP);
    localparam logic [15:0]        LFSR_SEED = 16'hACE1;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_e;

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    function automatic logic [1:0] popcount(input logic [NUM_SLOTS-1:0] v);
        logic [1:0] c;
        c = 2'd0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            c = c + {1'b0, v[i]};
        end
        return c;
    endfunction

    state_e                state_q, state_d;
    logic [NUM_SLOTS-1:0]  act_q, act_d;
    logic [NUM_SLOTS-1:0]  tall_q, tall_d;
    logic signed [9:0]     px_q [NUM_SLOTS];
    logic signed [9:0]     px_d [NUM_SLOTS];
    logic [GAP_W-1:0]      gap_q, gap_d;
    logic [15:0]           lfsr_q, lfsr_d;
    logic                  passed_q, passed_d;
    logic [1:0]            cnt_q, cnt_d;

    logic signed [10:0]    pxs_s [NUM_SLOTS];
    logic signed [10:0]    nx_s  [NUM_SLOTS];
    logic [NUM_SLOTS-1:0]  retire_s;
    logic [NUM_SLOTS-1:0]  spawn_oh_s;
    logic                  tick_s;
    logic                  spawn_s;
    logic signed [10:0]    xs_s;
    logic signed [10:0]    ys_s;
    logic                  hit_s;

    // Run/idle state follows the run input one cycle later
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (run) state_d = S_RUN;
                else     state_d = S_IDLE;
            end
            S_RUN: begin
                if (run) state_d = S_RUN;
                else     state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // A tick that coincides with clear is discarded
    assign tick_s     = frame_tick & run & (state_q == S_RUN) & ~clear;
    assign spawn_oh_s = ~act_q & (act_q + {{(NUM_SLOTS-1){1'b0}}, 1'b1});
    assign spawn_s    = (gap_q == '0) & (|(~act_q));

    // Per-slot scroll position after this frame and the off-screen test
    always_comb begin
        for (int i = 0; i < NUM_SLOTS; i++) begin
            pxs_s[i]    = $signed({px_q[i][9], px_q[i]});
            nx_s[i]     = pxs_s[i] - SPEED_S;
            retire_s[i] = act_q[i] & ((nx_s[i] + CW_S) <= 11'sd0);
        end
    end

    // Slot, gap counter and LFSR next-state for clear and tick processing
    always_comb begin
        act_d    = act_q;
        tall_d   = tall_q;
        px_d     = px_q;
        gap_d    = gap_q;
        lfsr_d   = lfsr_q;
        passed_d = 1'b0;
        if (clear) begin
            act_d = '0;
            gap_d = GAP_RST;
        end else if (tick_s) begin
            // spawn only targets slots free before this tick, so it never hits a retiring one
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (spawn_s && spawn_oh_s[i]) begin
                    act_d[i]  = 1'b1;
                    px_d[i]   = SPAWN_X;
                    tall_d[i] = lfsr_q[0];
                end else if (retire_s[i]) begin
                    act_d[i] = 1'b0;
                end else if (act_q[i]) begin
                    px_d[i] = nx_s[i][9:0];
                end else begin
                    px_d[i] = px_q[i];
                end
            end
            passed_d = |retire_s;
            if (gap_q != '0) begin
                gap_d = gap_q - GAP_W'(1);
            end else if (spawn_s) begin
                gap_d = GAP_RST + GAP_W'(lfsr_q[4:0] & GAP_MASK);
            end else begin
                gap_d = gap_q;
            end
            lfsr_d = lfsr_next(lfsr_q);
        end else begin
            passed_d = 1'b0;
        end
        cnt_d = popcount(act_d);
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            act_q    <= '0;
            tall_q   <= '0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                px_q[i] <= SPAWN_X;
            end
            gap_q    <= GAP_RST;
            lfsr_q   <= LFSR_SEED;
            passed_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            state_q  <= state_d;
            act_q    <= act_d;
            tall_q   <= tall_d;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                px_q[i] <= px_d[i];
            end
            gap_q    <= gap_d;
            lfsr_q   <= lfsr_d;
            passed_q <= passed_d;
            cnt_q    <= cnt_d;
        end
    end

    assign xs_s = {2'b00, x};
    assign ys_s = {3'b000, y};

    // Zero-latency pixel hit test; negative px clips without wrapping
    always_comb begin
        hit_s = 1'b0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            hit_s = hit_s | (act_q[i]
                          & (pxs_s[i] <= xs_s)
                          & (xs_s < (pxs_s[i] + CW_S))
                          & ((tall_q[i] ? TALL_TOP : SHORT_TOP) <= ys_s)
                          & (ys_s < FLOOR_S));
        end
    end

    assign r_cactus   = hit_s;
    assign passed     = passed_q;
    assign active_cnt = cnt_q;

endmodule

// File: tb/tb_team_08_cactus_scroller.sv
`timescale 1ns/1ps
// Directed bench: instance A (MIN_GAP=40) covers spawn/scroll/hit/freeze/clear/reset,
// instance B (MIN_GAP=1) covers full-slot behaviour and delayed refill.
module tb_team_08_cactus_scroller;

    logic       clk = 1'b0;
    logic       rst;
    logic       run;
    logic       clear;
    logic       frame_tick;
    logic [8:0] x;
    logic [7:0] y;
    logic       r_a, passed_a, r_b, passed_b;
    logic [1:0] cnt_a, cnt_b;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic        last_pa, last_pb;
    logic [15:0] lfsr_m;
    logic        tall1, tall2;
    int          h1;

    always #5 clk = ~clk;

    team_08_cactus_scroller #(
        .NUM_SLOTS(3), .SPEED(4), .CACTUS_W(12), .SHORT_H(20), .TALL_H(32),
        .FLOOR_Y(200), .MIN_GAP(40), .GAP_MASK(5'h00)
    ) u_dut_a (
        .clk(clk), .rst(rst), .run(run), .clear(clear), .frame_tick(frame_tick),
        .x(x), .y(y), .r_cactus(r_a), .passed(passed_a), .active_cnt(cnt_a)
    );

    team_08_cactus_scroller #(
        .NUM_SLOTS(3), .SPEED(4), .CACTUS_W(12), .SHORT_H(20), .TALL_H(32),
        .FLOOR_Y(200), .MIN_GAP(1), .GAP_MASK(5'h00)
    ) u_dut_b (
        .clk(clk), .rst(rst), .run(run), .clear(clear), .frame_tick(frame_tick),
        .x(x), .y(y), .r_cactus(r_b), .passed(passed_b), .active_cnt(cnt_b)
    );

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] lfsr_after(input int n);
        logic [15:0] v;
        v = 16'hACE1;
        for (int i = 0; i < n; i++) begin
            v = {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
        end
        return v;
    endfunction

    task automatic do_tick();
        @(negedge clk) frame_tick = 1'b1;
        @(negedge clk) frame_tick = 1'b0;
        #1;
        last_pa = passed_a;
        last_pb = passed_b;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) do_tick();
    endtask

    task automatic probe(input logic sel_b, input string tag, input int px, input int py,
                         input logic exp);
        @(negedge clk);
        x = 9'(px);
        y = 8'(py);
        #1;
        if (sel_b) check_eq(tag, 16'(r_b), 16'(exp));
        else       check_eq(tag, 16'(r_a), 16'(exp));
    endtask

    initial begin
        rst = 1'b1; run = 1'b0; clear = 1'b0; frame_tick = 1'b0; x = 9'd0; y = 8'd0;
        last_pa = 1'b0; last_pb = 1'b0;
        repeat (3) @(negedge clk);
        x = 9'd316; y = 8'd199;
        #1;
        check_eq("rst_cnt", 16'(cnt_a), 16'd0);
        check_eq("rst_passed", 16'(passed_a), 16'd0);
        check_eq("rst_hit", 16'(r_a), 16'd0);
        @(negedge clk) rst = 1'b0;

        // tick arriving with the rising run edge must be ignored
        @(negedge clk) begin run = 1'b1; frame_tick = 1'b1; end
        @(negedge clk) frame_tick = 1'b0;
        ticks(40);
        check_eq("no_spawn_t40", 16'(cnt_a), 16'd0);
        do_tick();
        check_eq("spawn_t41", 16'(cnt_a), 16'd1);
        lfsr_m = lfsr_after(40);
        tall1  = lfsr_m[0];
        h1     = tall1 ? 32 : 20;
        probe(1'b0, "px320_invisible", 319, 199, 1'b0);

        do_tick();
        probe(1'b0, "hit_left", 316, 199, 1'b1);
        probe(1'b0, "hit_right", 327, 199, 1'b1);
        probe(1'b0, "miss_right", 328, 199, 1'b0);
        probe(1'b0, "miss_left", 315, 199, 1'b0);
        probe(1'b0, "miss_floor", 316, 200, 1'b0);
        probe(1'b0, "hit_top", 316, 200 - h1, 1'b1);
        probe(1'b0, "miss_above", 316, 199 - h1, 1'b0);

        // frozen while run is low
        @(negedge clk) run = 1'b0;
        ticks(10);
        check_eq("freeze_cnt", 16'(cnt_a), 16'd1);
        probe(1'b0, "freeze_hit", 316, 199, 1'b1);
        probe(1'b0, "freeze_miss", 315, 199, 1'b0);
        @(negedge clk) run = 1'b1;
        @(negedge clk);

        ticks(39);
        check_eq("gap_held_t81", 16'(cnt_a), 16'd1);
        do_tick();
        check_eq("spawn_t82", 16'(cnt_a), 16'd2);
        lfsr_m = lfsr_after(81);
        tall2  = lfsr_m[0];
        do_tick();
        probe(1'b0, "slot1_height", 316, 168, tall2);
        probe(1'b0, "slot0_hit_152", 152, 199, 1'b1);
        probe(1'b0, "slot0_miss_151", 151, 199, 1'b0);

        ticks(38);
        do_tick();
        check_eq("cnt_t122", 16'(cnt_a), 16'd2);
        for (int i = 0; i < 8; i++) begin
            probe(1'b0, $sformatf("neg_px_hit_x%0d", i), i, 199, 1'b1);
        end
        probe(1'b0, "neg_px_miss_x8", 8, 199, 1'b0);

        do_tick();
        check_eq("spawn_t123", 16'(cnt_a), 16'd3);
        check_eq("no_pass_t123", 16'(last_pa), 16'd0);
        probe(1'b0, "clip_hit_x3", 3, 199, 1'b1);
        probe(1'b0, "clip_miss_x4", 4, 199, 1'b0);

        do_tick();
        check_eq("retire_pass", 16'(last_pa), 16'd1);
        check_eq("retire_cnt", 16'(cnt_a), 16'd2);
        @(negedge clk);
        #1;
        check_eq("pass_width", 16'(passed_a), 16'd0);
        probe(1'b0, "retired_miss", 0, 199, 1'b0);

        // clear together with a tick
        @(negedge clk) begin clear = 1'b1; frame_tick = 1'b1; end
        @(negedge clk) begin clear = 1'b0; frame_tick = 1'b0; end
        #1;
        check_eq("clear_cnt", 16'(cnt_a), 16'd0);
        check_eq("clear_pass", 16'(passed_a), 16'd0);
        probe(1'b0, "clear_miss1", 152, 199, 1'b0);
        probe(1'b0, "clear_miss2", 316, 199, 1'b0);
        ticks(40);
        check_eq("clear_gap40", 16'(cnt_a), 16'd0);
        do_tick();
        check_eq("clear_gap41", 16'(cnt_a), 16'd1);
        do_tick();
        probe(1'b0, "pre_rst_hit", 316, 199, 1'b1);

        // reset in the middle of a frame
        @(negedge clk) begin x = 9'd316; y = 8'd199; rst = 1'b1; end
        @(negedge clk) rst = 1'b0;
        #1;
        check_eq("mid_rst_hit", 16'(r_a), 16'd0);
        check_eq("mid_rst_cnt", 16'(cnt_a), 16'd0);
        check_eq("mid_rst_pass", 16'(passed_a), 16'd0);

        // instance B: MIN_GAP=1, spawns on ticks 2,4,6 (tall, tall, short from seed)
        do_tick();
        check_eq("b_t1", 16'(cnt_b), 16'd0);
        do_tick();
        check_eq("b_t2", 16'(cnt_b), 16'd1);
        do_tick();
        check_eq("b_t3", 16'(cnt_b), 16'd1);
        probe(1'b1, "b_slot0_tall", 316, 168, 1'b1);
        do_tick();
        check_eq("b_t4", 16'(cnt_b), 16'd2);
        ticks(2);
        check_eq("b_t6", 16'(cnt_b), 16'd3);
        ticks(2);
        probe(1'b1, "b_slot2_short_miss", 318, 168, 1'b0);
        probe(1'b1, "b_slot2_short_hit", 318, 180, 1'b1);
        ticks(76);
        check_eq("b_full_t84", 16'(cnt_b), 16'd3);
        check_eq("b_nopass_t84", 16'(last_pb), 16'd0);
        do_tick();
        check_eq("b_retire_t85", 16'(cnt_b), 16'd2);
        check_eq("b_pass_t85", 16'(last_pb), 16'd1);
        do_tick();
        check_eq("b_refill_t86", 16'(cnt_b), 16'd3);
        do_tick();
        check_eq("b_retire_t87", 16'(cnt_b), 16'd2);
        check_eq("b_pass_t87", 16'(last_pb), 16'd1);
        probe(1'b1, "b_refill_hit", 316, 199, 1'b1);
        do_tick();
        check_eq("b_refill_t88", 16'(cnt_b), 16'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
